// File: rtl/ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// ram_fifo_ctrl
// Pointer/occupancy controller for a FIFO built around an external RAM that
// has a registered read port. The requester drives the RAM write data itself;
// this block only decides whether a push or pop is accepted, supplies the RAM
// addresses and enables, and tracks the occupancy and the sticky error flags.
//
// Ports
//   clk             : single clock, all state updates on its rising edge
//   rst             : asynchronous active-high reset
//   i_push          : write request (data goes straight to RAM din)
//   i_pop           : read request
//   i_clr_err       : synchronous clear of o_overflow / o_underflow
//   o_ram_we        : RAM write enable (accepted push)
//   o_ram_wr_addr   : RAM write address (write pointer)
//   o_ram_re        : RAM read enable (accepted pop)
//   o_ram_re_addr   : RAM read address (read pointer)
//   o_rd_valid      : RAM dout holds the popped entry this cycle
//   o_count         : occupancy, 0..DEPTH
//   o_full          : occupancy == DEPTH
//   o_empty         : occupancy == 0
//   o_almost_full   : occupancy >= AF_LEVEL
//   o_overflow      : sticky, set by a push rejected because the FIFO was full
//   o_underflow     : sticky, set by a pop rejected because the FIFO was empty
// ----------------------------------------------------------------------------
module ram_fifo_ctrl #(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int DW       = 8,
   parameter int AF_LEVEL = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_clr_err,
   output logic          o_ram_we,
   output logic [AW-1:0] o_ram_wr_addr,
   output logic          o_ram_re,
   output logic [AW-1:0] o_ram_re_addr,
   output logic          o_rd_valid,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_almost_full,
   output logic          o_overflow,
   output logic          o_underflow
);

   // Pointers wrap by plain binary overflow, so DEPTH must be exactly 2**AW.
   // DW only describes the RAM this block is paired with.
   generate
      if (DEPTH != (1 << AW)) begin : g_chk_depth
         $error("ram_fifo_ctrl: DEPTH must equal 2**AW");
      end
      if (DW < 1) begin : g_chk_dw
         $error("ram_fifo_ctrl: DW must be at least 1");
      end
   endgenerate

   localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   C_AF    = (AW+1)'(AF_LEVEL);
   localparam logic [AW-1:0] C_PTR1  = AW'(1);
   localparam logic [AW:0]   C_CNT1  = (AW+1)'(1);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_rd_valid;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_full;
   logic          w_empty;
   logic          w_push_acc;
   logic          w_pop_acc;
   logic          w_push_rej;
   logic          w_pop_rej;
   logic [AW:0]   w_count_next;

   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);

   // Acceptance is judged on the occupancy before this edge only: a pop does
   // not make room for a same-cycle push, and a push does not feed a same-cycle
   // pop. That keeps the write and read addresses distinct whenever both
   // enables are high, so no RAM bypass is needed. rst masks the enables so
   // nothing reaches the RAM while the block is held in reset.
   assign w_push_acc = i_push & ~w_full  & ~rst;
   assign w_pop_acc  = i_pop  & ~w_empty & ~rst;
   assign w_push_rej = i_push & w_full;
   assign w_pop_rej  = i_pop  & w_empty;

   always_comb begin
      w_count_next = r_count;
      case ({w_push_acc, w_pop_acc})
         2'b10:   w_count_next = r_count + C_CNT1;
         2'b01:   w_count_next = r_count - C_CNT1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + C_PTR1;
         end
         if (w_pop_acc) begin
            r_rd_ptr <= r_rd_ptr + C_PTR1;
         end
         r_count    <= w_count_next;
         // RAM dout is registered, so the popped word is visible one cycle
         // after the read enable.
         r_rd_valid <= w_pop_acc;
         // A new rejection wins over a coincident clear.
         r_overflow  <= w_push_rej | (r_overflow  & ~i_clr_err);
         r_underflow <= w_pop_rej  | (r_underflow & ~i_clr_err);
      end
   end

   assign o_ram_we      = w_push_acc;
   assign o_ram_re      = w_pop_acc;
   assign o_ram_wr_addr = r_wr_ptr;
   assign o_ram_re_addr = r_rd_ptr;
   assign o_rd_valid    = r_rd_valid;
   assign o_count       = r_count;
   assign o_full        = w_full;
   assign o_empty       = w_empty;
   assign o_almost_full = (r_count >= C_AF);
   assign o_overflow    = r_overflow;
   assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Drives ram_fifo_ctrl together with a behavioural RAM (registered read). The
// reference model is a data queue plus accepted-operation counters; expected
// read data is queued on each accepted pop and a separate monitor checks it
// whenever rd_valid is seen.
// ----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

   localparam int DEPTH    = 16;
   localparam int AW       = 4;
   localparam int DW       = 8;
   localparam int AF_LEVEL = 12;

   logic          clk;
   logic          rst;
   logic          push;
   logic          pop;
   logic          clr_err;
   logic          ram_we;
   logic [AW-1:0] ram_wr_addr;
   logic          ram_re;
   logic [AW-1:0] ram_re_addr;
   logic          rd_valid;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          overflow;
   logic          underflow;

   logic [DW-1:0] din;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] mem [DEPTH];

   ram_fifo_ctrl #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .DW      (DW),
      .AF_LEVEL(AF_LEVEL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_push       (push),
      .i_pop        (pop),
      .i_clr_err    (clr_err),
      .o_ram_we     (ram_we),
      .o_ram_wr_addr(ram_wr_addr),
      .o_ram_re     (ram_re),
      .o_ram_re_addr(ram_re_addr),
      .o_rd_valid   (rd_valid),
      .o_count      (count),
      .o_full       (full),
      .o_empty      (empty),
      .o_almost_full(almost_full),
      .o_overflow   (overflow),
      .o_underflow  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM with a registered read port.
   always @(posedge clk) begin
      if (ram_we) mem[ram_wr_addr] <= din;
      if (ram_re) ram_dout <= mem[ram_re_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model
   logic [DW-1:0] mq[$];
   int  m_wr  = 0;
   int  m_rd  = 0;
   bit  m_ovf = 1'b0;
   bit  m_unf = 1'b0;

   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic model_reset();
      mq.delete();
      sb.delete();
      m_wr  = 0;
      m_rd  = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic check_state();
      chk("count",       count,       mq.size());
      chk("empty",       empty,       mq.size() == 0);
      chk("full",        full,        mq.size() == DEPTH);
      chk("almost_full", almost_full, mq.size() >= AF_LEVEL);
      chk("overflow",    overflow,    m_ovf);
      chk("underflow",   underflow,   m_unf);
   endtask

   // One clock of stimulus: inputs change just after the falling edge, the
   // registered state and the combinational enables are checked 1 ns later,
   // then the model advances as the next rising edge will.
   task automatic step(input bit p, input bit q, input bit c, input logic [DW-1:0] d);
      bit pa;
      bit qa;
      @(negedge clk);
      push    = p;
      pop     = q;
      clr_err = c;
      din     = d;
      #1;
      check_state();
      pa = p && (mq.size() < DEPTH);
      qa = q && (mq.size() > 0);
      chk("ram_we", ram_we, pa);
      chk("ram_re", ram_re, qa);
      if (pa) chk("ram_wr_addr", ram_wr_addr, m_wr);
      if (qa) chk("ram_re_addr", ram_re_addr, m_rd);
      m_ovf = (p && !pa) || (m_ovf && !c);
      m_unf = (q && !qa) || (m_unf && !c);
      if (qa) begin
         sb.push_back('{d: mq.pop_front(), due: cyc + 1});
         m_rd = (m_rd + 1) % DEPTH;
      end
      if (pa) begin
         mq.push_back(d);
         m_wr = (m_wr + 1) % DEPTH;
      end
   endtask

   // Monitor: every rd_valid consumes one expected word, and a word whose
   // due cycle passes without rd_valid is reported as missing.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("rd_valid_unexpected", rd_valid, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("rd_due_cycle", cyc, mon_e.due);
            chk("rd_data", ram_dout, mon_e.d);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         chk("rd_valid_missing", rd_valid, 1);
         void'(sb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pp;
      int qp;
      rst     = 1'b1;
      push    = 1'b1;
      pop     = 1'b1;
      clr_err = 1'b0;
      din     = '0;
      model_reset();

      // Held in reset with both requests high: nothing may be enabled.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_ram_we",   ram_we,      0);
      chk("rst_ram_re",   ram_re,      0);
      chk("rst_empty",    empty,       1);
      chk("rst_full",     full,        0);
      chk("rst_af",       almost_full, 0);
      chk("rst_count",    count,       0);
      chk("rst_rd_valid", rd_valid,    0);
      rst  = 1'b0;
      push = 1'b0;
      pop  = 1'b0;

      // Fill with 0x00..0x0F, then one push too many.
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
      step(1'b1, 1'b0, 1'b0, 8'hAA);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ovf_after_17th", overflow, 1);
      chk("count_held_16",  count,    16);

      // Drain completely; data order is checked by the monitor.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);

      // Push and pop from empty: pop rejected, underflow sticks until cleared.
      step(1'b1, 1'b1, 1'b0, 8'h55);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      // Now empty: a rejected pop together with clr_err keeps the flag set.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Bring wr_ptr to 14 with five entries, then run push+pop across wrap.
      for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
      for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'($urandom));
         chk("wrap_wr_addr", ram_wr_addr, (14 + i) % DEPTH);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("wrap_wr_addr_end", ram_wr_addr, 2);
      chk("wrap_count",       count,       5);

      // Reach 9 entries with a pop in flight, then reset between edges.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
      step(1'b1, 1'b1, 1'b0, 8'($urandom));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      @(posedge clk);
      #2;
      rst  = 1'b1;
      push = 1'b1;
      sb.delete();
      #1;
      chk("async_rst_count",    count,    0);
      chk("async_rst_empty",    empty,    1);
      chk("async_rst_rd_valid", rd_valid, 0);
      chk("async_rst_ram_we",   ram_we,   0);
      chk("async_rst_ram_re",   ram_re,   0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      push = 1'b0;
      pop  = 1'b0;

      // Randomized traffic in phases of differing push/pop bias.
      for (int ph = 0; ph < 6; ph++) begin
         case (ph % 3)
            0:       begin pp = 75; qp = 30; end
            1:       begin pp = 30; qp = 75; end
            default: begin pp = 55; qp = 55; end
         endcase
         for (int i = 0; i < 100; i++) begin
            step($urandom_range(99) < pp, $urandom_range(99) < qp,
                 $urandom_range(15) == 0, 8'($urandom));
         end
      end

      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the number of RAM entries (power of two).
REQ-002 The block SHALL have parameter AW, default 4, the RAM address width (log2 DEPTH).
REQ-003 The block SHALL have parameter DW, default 8, the RAM data width; it is informational only and drives no logic.
REQ-004 The block SHALL have parameter AF_LEVEL, default 12, the almost-full threshold in entries.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port push, input, 1 bit: write request; the write data is presented directly to RAM din by the requester.
REQ-008 The block SHALL have port pop, input, 1 bit: read request.
REQ-009 The block SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-010 The block SHALL have port ram_we, output, 1 bit: RAM write enable.
REQ-011 The block SHALL have port ram_wr_addr, output, AW bits: RAM write address.
REQ-012 The block SHALL have port ram_re, output, 1 bit: RAM read enable.
REQ-013 The block SHALL have port ram_re_addr, output, AW bits: RAM read address.
REQ-014 The block SHALL have port rd_valid, output, 1 bit: RAM dout holds popped data this cycle.
REQ-015 The block SHALL have port count, output, AW+1 bits: current occupancy, 0..DEPTH.
REQ-016 The block SHALL have ports full, empty and almost_full, each an output of 1 bit: occupancy flags.
REQ-017 The block SHALL have ports overflow and underflow, each an output of 1 bit: sticky error flags.

Function
REQ-018 The block SHALL hold registered state wr_ptr (AW), rd_ptr (AW), count (AW+1), rd_valid, overflow and underflow.
REQ-019 The block SHALL drive ram_we = push AND NOT full, combinationally (accepted push).
REQ-020 The block SHALL drive ram_re = pop AND NOT empty, combinationally (accepted pop).
REQ-021 The block SHALL drive ram_wr_addr = wr_ptr and ram_re_addr = rd_ptr, with no added latency.
REQ-022 On an accepted push, wr_ptr SHALL increment by 1 modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-023 On an accepted pop, rd_ptr SHALL increment by 1 modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-024 count SHALL update as follows: +1 on an accepted push only; -1 on an accepted pop only; unchanged when both or neither are accepted.
REQ-025 The flags SHALL be combinational decodes of count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL).
REQ-026 rd_valid SHALL be 1 in the cycle after an accepted pop and 0 otherwise, giving 1-cycle read latency matching the registered RAM dout.
REQ-027 When full, a push SHALL be rejected even if a pop is accepted in the same cycle; count then decrements to DEPTH-1.
REQ-028 When empty, a pop SHALL be rejected even if a push is accepted in the same cycle; count then increments to 1.
REQ-029 A rejected push SHALL set overflow to 1 at the next edge; it holds until clr_err or rst.
REQ-030 A rejected pop SHALL set underflow to 1 at the next edge; it holds until clr_err or rst.
REQ-031 When clr_err coincides with a new rejection, the set SHALL take priority and the flag stays 1.
REQ-032 ram_we and ram_re SHALL never address the same entry in the same cycle; the gating in REQ-027 and REQ-028 guarantees this, and the block SHALL need no bypass path.
REQ-033 count SHALL never exceed DEPTH or underflow below 0 under any input sequence.

Reset
REQ-034 While rst is high, the block SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0 and underflow=0.
REQ-035 While rst is high, the outputs SHALL read empty=1, full=0, almost_full=0, ram_we=0 and ram_re=0 regardless of push or pop.
REQ-036 An assertion of rst mid-operation SHALL discard all stored entries, and no in-flight rd_valid SHALL appear after reset.
REQ-037 After rst deasserts, the block SHALL accept requests from the first rising clk edge.

Verification
REQ-038 The bench SHALL cover: reset, then 16 pushes of 0x00..0x0F -> ram_wr_addr 0..15 in order; full=1 and count=16 after the 16th; almost_full=1 from count=12.
REQ-039 The bench SHALL cover: from full, a 17th push -> ram_we=0, overflow=1 the next cycle; count stays 16.
REQ-040 The bench SHALL cover: from full, 16 pops -> rd_valid each following cycle with RAM dout 0x00..0x0F; empty=1 at the end.
REQ-041 The bench SHALL cover: from empty, push and pop together -> pop rejected, underflow=1, count=1; then clr_err -> underflow=0.
REQ-042 The bench SHALL cover: at count=5 with pointers near wrap (wr_ptr=14), simultaneous push and pop for 4 cycles -> count stays 5 and wr_ptr wraps 14,15,0,1,2.
REQ-043 The bench SHALL cover: rst asserted asynchronously between edges at count=9 -> count=0, empty=1 immediately, and no rd_valid pulse afterwards.
